// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared state encoding and width helper for the reset sequencer.
// Revision : 1.0
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        STRETCH = 2'b01,
        GAP     = 2'b10,
        DONE    = 2'b11
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : rst_sync_chain
// Brief    : Async-assert, synchronous-release reset synchroniser chain.
// Revision : 1.0
// ============================================================================
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_ok
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_sync
// Brief    : Reset synchroniser plus stretch and staggered per-channel release.
// Revision : 1.0
// ============================================================================
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int NUM_CH      = 4,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_busy,
    output logic              seq_done
);

    localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] C_STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX     = IDX_W'(NUM_CH - 1);

    logic              sync_ok;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    rst_sync_chain #(
        .STAGES (STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sync_ok (sync_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;

        // Software request restarts the stretch, but only once the chain has released.
        if (sw_rst_req && (state_q != HOLD)) begin
            state_d = STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (sync_ok) begin
                        state_d = STRETCH;
                        cnt_d   = '0;
                    end
                end
                STRETCH: begin
                    if (cnt_q == C_STRETCH_LAST) begin
                        rst_n_d[0] = 1'b1;
                        cnt_d      = '0;
                        idx_d      = IDX_W'(1);
                        state_d    = (NUM_CH > 1) ? GAP : DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == C_GAP_LAST) begin
                        rst_n_d[idx_q] = 1'b1;
                        cnt_d          = '0;
                        idx_d          = idx_q + 1'b1;
                        if (idx_q == C_LAST_IDX) begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = ~&rst_n_d;
        done_d = &rst_n_d;
    end

    assign rst_n_out = rst_n_q;
    assign seq_busy  = busy_q;
    assign seq_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_sync
// Brief    : Scoreboard bench for two rst_seq_sync configurations.
// Revision : 1.0
// ============================================================================
module tb_rst_seq_sync;

    localparam int ST0 = 2, NC0 = 4, SC0 = 16, GC0 = 8;
    localparam int ST1 = 3, NC1 = 1, SC1 = 1,  GC1 = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_n_out0;
    logic       busy0, done0;
    logic [0:0] rst_n_out1;
    logic       busy1, done1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic [3:0] b0;
        logic       b1;
    } exp_t;
    exp_t exp_q[$];

    // Edges since rst deassertion, and the edge from which each stretch is counted.
    int n  = 0;
    int s0 = ST0 + 1;
    int s1 = ST1 + 1;

    always #5 clk = ~clk;

    rst_seq_sync #(
        .STAGES(ST0), .NUM_CH(NC0), .STRETCH_CYC(SC0), .GAP_CYC(GC0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .rst_n_out(rst_n_out0), .seq_busy(busy0), .seq_done(done0)
    );

    rst_seq_sync #(
        .STAGES(ST1), .NUM_CH(NC1), .STRETCH_CYC(SC1), .GAP_CYC(GC1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .rst_n_out(rst_n_out1), .seq_busy(busy1), .seq_done(done1)
    );

    // Channel i is released once edge start+STRETCH+i*GAP has been reached.
    function automatic logic [3:0] released(input int edge_n, input int start,
                                            input int s, input int g, input int nch);
        logic [3:0] r;
        r = '0;
        if (edge_n > 0) begin
            for (int i = 0; i < nch; i++) begin
                if (edge_n >= start + s + i * g) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, n, got, want);
        end
    endtask

    task automatic cycle(input logic sw);
        exp_t e;
        logic [3:0] r1;
        sw_rst_req = sw;
        @(posedge clk);
        if (rst) begin
            n  = 0;
            s0 = ST0 + 1;
            s1 = ST1 + 1;
        end else begin
            n++;
            if (sw && n >= ST0 + 2) s0 = n;
            if (sw && n >= ST1 + 2) s1 = n;
        end
        e.n  = n;
        e.b0 = released(n, s0, SC0, GC0, NC0);
        r1   = released(n, s1, SC1, GC1, NC1);
        e.b1 = r1[0];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int cycles, input logic sw);
        for (int i = 0; i < cycles; i++) cycle(sw);
    endtask

    // Called at a falling edge: a 3 ns rst pulse that never spans a rising edge.
    task automatic rst_pulse();
        #1 rst = 1'b1;
        #1;
        check("async_rst_n_out0", int'(rst_n_out0), 0);
        check("async_rst_n_out1", int'(rst_n_out1), 0);
        check("async_busy0", int'(busy0), 1);
        check("async_done0", int'(done0), 0);
        #2 rst = 1'b0;
        n  = 0;
        s0 = ST0 + 1;
        s1 = ST1 + 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rst_n_out0", int'(rst_n_out0), int'(e.b0));
                check("seq_done0", int'(done0), int'(e.b0 == 4'hF));
                check("seq_busy0", int'(busy0), int'(e.b0 != 4'hF));
                check("rst_n_out1", int'(rst_n_out1), int'(e.b1));
                check("seq_done1", int'(done1), int'(e.b1));
                check("seq_busy1", int'(busy1), int'(!e.b1));
            end
        end
    end

    initial begin : driver
        @(negedge clk);
        run(5, 1'b0);
        rst = 1'b0;
        run(50, 1'b0);

        rst_pulse();
        run(48, 1'b0);

        cycle(1'b1);
        run(30, 1'b0);
        run(10, 1'b1);
        run(50, 1'b0);

        rst_pulse();
        run(10, 1'b0);
        rst_pulse();
        run(50, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) rst_pulse();
            cycle($urandom_range(0, 15) == 0);
        end
        run(60, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
